// File: rtl/aftab_adder_sequencer_pkg.sv
// aftab_adder_sequencer_pkg
//   Shared types and helpers for the chunked add/subtract sequencer.
//   state_e : sequencer FSM states (IDLE, RUN, DONE)
//   clog2   : width of the chunk counter for a given chunk count
package aftab_adder_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Minimum of 1 so a counter is always at least one bit wide.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/aftab_adder.sv
// aftab_adder
//   Combinational size-bit ripple adder with carry in/out.
//   Cin  : carry in
//   A, B : size-bit addends
//   S    : size-bit sum
//   Cout : carry out of the top bit
module aftab_adder #(
   parameter int unsigned size = 32
) (
   input  logic            Cin,
   input  logic [size-1:0] A,
   input  logic [size-1:0] B,
   output logic [size-1:0] S,
   output logic            Cout
);

   logic [size:0] full;

   always_comb begin
      full = {1'b0, A} + {1'b0, B} + {{size{1'b0}}, Cin};
   end

   assign S    = full[size-1:0];
   assign Cout = full[size];

endmodule

// File: rtl/aftab_adder_sequencer.sv
// aftab_adder_sequencer
//   Multi-cycle WIDTH-bit A+B / A-B built from one CHUNK-bit aftab_adder,
//   processing WIDTH/CHUNK chunks least-significant first with the carry
//   registered between chunks. WIDTH must be a multiple of CHUNK and
//   WIDTH/CHUNK must be at least 2.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   start    : request, accepted in IDLE or DONE
//   sub      : 0 = A+B, 1 = A-B (sampled with start)
//   opA, opB : operands (sampled with start)
//   busy     : high while chunks are being processed
//   done     : one-cycle pulse, result/cout/ovf valid from this cycle on
//   result   : sum or difference, held until the next accepted start
//   cout     : final carry out (for sub, 1 means no borrow)
//   ovf      : signed overflow of the full-width operation
import aftab_adder_sequencer_pkg::*;

module aftab_adder_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CW     = clog2(NCHUNK);

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic             sub_q,    sub_d;
   logic             carry_q,  carry_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q,   cout_d;
   logic             ovf_q,    ovf_d;

   logic [CHUNK-1:0] b_eff;
   logic [CHUNK-1:0] sum;
   logic             co;

   // Operand registers are shifted right each RUN cycle, so the active
   // chunk is always the low CHUNK bits.
   assign b_eff = b_q[CHUNK-1:0] ^ {CHUNK{sub_q}};

   aftab_adder #(.size(CHUNK)) u_adder (
      .Cin  (carry_q),
      .A    (a_q[CHUNK-1:0]),
      .B    (b_eff),
      .S    (sum),
      .Cout (co)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = opA;
               b_d     = opB;
               sub_d   = sub;
               carry_d = sub;   // +1 of the two's complement for A-B
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Sum chunks enter from the top; after NCHUNK shifts chunk 0
            // has reached the bottom and the result is in place.
            result_d = {sum, result_q[WIDTH-1:CHUNK]};
            a_d      = a_q >> CHUNK;
            b_d      = b_q >> CHUNK;
            carry_d  = co;
            // cout/ovf are updated every chunk; only the last chunk's
            // values (taken from the operand MSBs) survive to DONE.
            cout_d   = co;
            ovf_d    = (a_q[CHUNK-1] == b_eff[CHUNK-1]) &&
                       (sum[CHUNK-1] != a_q[CHUNK-1]);
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(NCHUNK - 1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_aftab_adder_sequencer.sv
// tb_aftab_adder_sequencer
//   Self-checking bench: directed cases plus randomized operations compared
//   against a full-width arithmetic reference model.
module tb_aftab_adder_sequencer;

   localparam int W      = 32;
   localparam int C      = 8;
   localparam int NCHUNK = W / C;

   logic         clk;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] opA;
   logic [W-1:0] opB;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int n_cmp;
   int n_err;
   logic [W-1:0] last_r;

   aftab_adder_sequencer #(.WIDTH(W), .CHUNK(C)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sub    (sub),
      .opA    (opA),
      .opB    (opB),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word two's complement arithmetic.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic co, output logic ov);
      logic [W-1:0] beff;
      logic [W:0]   full;
      beff = s ? ~b : b;
      full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, s};
      r    = full[W-1:0];
      co   = full[W];
      ov   = (a[W-1] == beff[W-1]) && (r[W-1] != a[W-1]);
   endtask

   // Called at a negedge; leaves start low with scrambled inputs after acceptance.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      opA = a; opB = b; sub = s; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      opA = $urandom; opB = $urandom; sub = 1'($urandom);
   endtask

   // Follows an accepted op through RUN to DONE; pulse_at >= 0 raises start
   // in that RUN cycle to confirm it is ignored. Ends at the DONE negedge.
   task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input int pulse_at);
      logic [W-1:0] er;
      logic         ec, eo;
      model(a, b, s, er, ec, eo);
      for (int i = 0; i < NCHUNK; i++) begin
         @(negedge clk);
         start = 1'b0;
         check({tag, "/busy"}, 64'(busy), 64'd1);
         check({tag, "/nodone"}, 64'(done), 64'd0);
         if (i == pulse_at) begin
            start = 1'b1; opA = $urandom; opB = $urandom; sub = 1'($urandom);
         end
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "/done"}, 64'(done), 64'd1);
      check({tag, "/busy_lo"}, 64'(busy), 64'd0);
      check({tag, "/result"}, 64'(result), 64'(er));
      check({tag, "/cout"}, 64'(cout), 64'(ec));
      check({tag, "/ovf"}, 64'(ovf), 64'(eo));
      last_r = er;
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      check({tag, "/idle_busy"}, 64'(busy), 64'd0);
      check({tag, "/idle_done"}, 64'(done), 64'd0);
      check({tag, "/idle_hold"}, 64'(result), 64'(last_r));
   endtask

   task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      launch(a, b, s);
      finish_op(tag, a, b, s, -1);
      idle_check(tag);
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(5))
         0: v = '0;
         1: v = '1;
         2: v = 32'h8000_0000;
         3: v = 32'h7FFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      n_cmp = 0; n_err = 0; last_r = '0;
      rst = 1'b1; start = 1'b0; sub = 1'b0; opA = '0; opB = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset/busy", 64'(busy), 64'd0);
      check("reset/done", 64'(done), 64'd0);
      check("reset/result", 64'(result), 64'd0);
      check("reset/cout", 64'(cout), 64'd0);
      check("reset/ovf", 64'(ovf), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      op("borrow", 32'd5, 32'd7, 1'b1);
      op("noborrow", 32'd7, 32'd5, 1'b1);
      op("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0);
      op("ovf_sub", 32'h8000_0000, 32'd1, 1'b1);

      // start during RUN is ignored; exactly one done follows.
      launch(32'h1234_5678, 32'h1111_1111, 1'b0);
      finish_op("ignore", 32'h1234_5678, 32'h1111_1111, 1'b0, 1);
      check("ignore/value", 64'(result), 64'h2345_6789);
      idle_check("ignore1");
      idle_check("ignore2");

      // Reset in the third RUN cycle aborts without a done.
      launch(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort/busy", 64'(busy), 64'd0);
      check("abort/done", 64'(done), 64'd0);
      check("abort/result", 64'(result), 64'd0);
      check("abort/cout", 64'(cout), 64'd0);
      check("abort/ovf", 64'(ovf), 64'd0);
      last_r = '0;
      for (int i = 0; i < 6; i++) idle_check("abort_quiet");

      // Back-to-back: start held through DONE, no idle bubble.
      launch(32'h0000_00FF, 32'h0000_0001, 1'b0);
      finish_op("b2b_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, -1);
      check("b2b_1/value", 64'(result), 64'h0000_0100);
      launch(32'h0000_00FF, 32'h0000_0001, 1'b0);
      finish_op("b2b_2", 32'h0000_00FF, 32'h0000_0001, 1'b0, -1);
      check("b2b_2/value", 64'(result), 64'h0000_0100);
      launch(32'hCAFE_F00D, 32'h0BAD_F00D, 1'b1);
      finish_op("b2b_3", 32'hCAFE_F00D, 32'h0BAD_F00D, 1'b1, -1);
      idle_check("b2b_3");

      for (int k = 0; k < 60; k++) begin
         logic [W-1:0] a, b;
         logic         s;
         a = pick(); b = pick(); s = 1'($urandom);
         launch(a, b, s);
         finish_op("rand", a, b, s, ($urandom_range(3) == 0) ? int'($urandom_range(NCHUNK - 1)) : -1);
         if ($urandom_range(1) == 0) idle_check("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
